obstacle_collision_detector: RTL and testbench
==============================================

Name: obstacle_collision_detector

Overview:
- Sits directly downstream of the obstacle drawing blocks (pillars, etc.).
- Consumes their per-pixel obstacle_x/obstacle_y outputs and the mouse pointer position, and detects overlap between obstacle pixels and the pointer box.
- Manages player HP, a post-hit invulnerability window counted in frames, and a game-over flag.
- Feeds the game control FSM and the HUD.

Parameters:
POINTER_W, 16, pointer box width in pixels
POINTER_H, 16, pointer box height in pixels
MAX_HP, 3, HP loaded on game start (1..15)
INVULN_FRAMES, 60, frames of invulnerability after a hit (1..255)

Ports:
pclk  in  1  pixel clock
rst  in  1  synchronous active-high reset
hcount_in  in  12  current pixel column
vcount_in  in  12  current pixel row
obstacle_x  in  12  obstacle pixel column; 0 together with obstacle_y = 0 means no obstacle pixel
obstacle_y  in  12  obstacle pixel row
mouse_xpos  in  12  pointer top-left column
mouse_ypos  in  12  pointer top-left row
game_start  in  1  one-cycle pulse: load HP and begin play
menu_on  in  1  menu active; abort play
hp  out  4  remaining HP
hit  out  1  one-cycle pulse per accepted hit
invulnerable  out  1  high during the invulnerability window
game_over  out  1  high when HP reaches 0; held until game_start or rst

Behaviour:
- Reset is synchronous and active-high on pclk. It forces:
  - state = IDLE
  - hp = 0, hit = 0, invulnerable = 0, game_over = 0
  - frame counter = 0
  - latched mouse position = 0
- All outputs are registered.
- Frame start (frame_sof) is defined as hcount_in == 0 && vcount_in == 0.
- mouse_xpos and mouse_ypos are latched into mx_l and my_l on frame_sof. Comparisons use only the latched values, so the pointer cannot tear mid-frame.
- Overlap condition, evaluated combinationally on the current inputs:
  - (obstacle_x != 0 || obstacle_y != 0)
  - obstacle_x >= mx_l and obstacle_x <= mx_l + POINTER_W - 1
  - obstacle_y >= my_l and obstacle_y <= my_l + POINTER_H - 1
  - Sums are computed at 13 bits so no wrap occurs near 4095.
- States: IDLE, PLAY, INVULN, DEAD.
- IDLE:
  - game_start -> PLAY, hp <= MAX_HP, game_over <= 0.
  - Overlap is ignored.
- PLAY:
  - menu_on -> IDLE with hp held (menu_on has priority over overlap).
  - Otherwise, on overlap:
    - hit <= 1 on the next cycle (latency 1).
    - hp <= hp - 1.
    - If hp == 1 -> DEAD, game_over <= 1.
    - Else -> INVULN, invulnerable <= 1, frame counter <= INVULN_FRAMES.
- INVULN:
  - Overlap is ignored (no hit, no HP change).
  - Counter decrements on each frame_sof.
  - When counter == 1 and frame_sof -> PLAY, invulnerable <= 0, counter <= 0.
  - menu_on -> IDLE, invulnerable <= 0.
- DEAD:
  - game_over held at 1, hp = 0, overlap ignored.
  - game_start -> PLAY, hp <= MAX_HP, game_over <= 0.
  - menu_on has no effect.
- Simultaneous events:
  - game_start together with overlap in IDLE/DEAD: load HP only; overlap is not counted that cycle.
  - frame_sof together with overlap in PLAY: the hit is taken and uses the mx_l value before the update.
- Multiple overlapping pixels within one frame produce exactly one hit, because the block enters INVULN immediately.
- hp never underflows below 0.
- hit is never high for two consecutive cycles.
- Reset mid-INVULN or mid-DEAD returns all outputs to reset values on the next edge.

Test Plan:
1. rst held 2 cycles, then game_start pulse -> hp = 3, state PLAY, game_over = 0, invulnerable = 0.
2. mouse latched at (500,450); obstacle_x = 507, obstacle_y = 460 for one cycle -> hit = 1 for exactly one cycle, hp = 2, invulnerable = 1.
3. Same overlap repeated for 200 further cycles within INVULN -> no hit, hp stays 2. After 60 frame_sof events -> invulnerable = 0.
4. Obstacle at (515,465) and at (516,450) with mouse at (500,450) -> first causes a hit (edge inclusive), second does not. obstacle_x = 0, obstacle_y = 0 with mouse at (0,0) -> no hit.
5. Three separated hits from hp = 3 -> hp 2, 1, 0. game_over = 1 after the third. Further overlap gives no hit. game_start -> hp = 3, game_over = 0.
6. menu_on in PLAY with a simultaneous overlap -> IDLE, no hit, hp unchanged. rst asserted during INVULN -> hp = 0, invulnerable = 0, IDLE next cycle.

Source files
------------

// File: rtl/obstacle_collision_detector.sv
// -----------------------------------------------------------------------------
// obstacle_collision_detector
//
// Purpose:
//   Sits downstream of the obstacle drawing blocks. Every pixel clock it checks
//   whether the obstacle pixel reported by those blocks falls inside the mouse
//   pointer box. It also tracks player HP, a post-hit invulnerability window
//   measured in frames, and a game-over flag. Its outputs feed the game control
//   FSM and the HUD.
//
// Ports:
//   pclk           pixel clock
//   rst            synchronous active-high reset
//   hcount_in      current pixel column (12 bit)
//   vcount_in      current pixel row (12 bit)
//   obstacle_x/_y  obstacle pixel position; (0,0) means "no obstacle pixel"
//   mouse_xpos/_ypos  pointer top-left corner, latched once per frame
//   game_start     one-cycle pulse: load HP and begin play
//   menu_on        menu active: abort play (ignored once dead)
//   hp             remaining HP
//   hit            one-cycle pulse for each accepted hit
//   invulnerable   high for the invulnerability window after a hit
//   game_over      high once HP reaches 0, held until game_start or rst
// -----------------------------------------------------------------------------
module obstacle_collision_detector #(
    parameter int POINTER_W     = 16,
    parameter int POINTER_H     = 16,
    parameter int MAX_HP        = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        game_start,
    input  logic        menu_on,
    output logic [3:0]  hp,
    output logic        hit,
    output logic        invulnerable,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        INVULN,
        DEAD
    } state_e;

    localparam logic [3:0]  HP_LOAD  = 4'(MAX_HP);
    localparam logic [7:0]  INV_LOAD = 8'(INVULN_FRAMES);
    localparam logic [12:0] W_SPAN   = 13'(POINTER_W - 1);
    localparam logic [12:0] H_SPAN   = 13'(POINTER_H - 1);

    state_e      state_q, state_d;
    logic [3:0]  hp_q, hp_d;
    logic        hit_q, hit_d;
    logic        inv_q, inv_d;
    logic        go_q, go_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] mx_q, mx_d;
    logic [11:0] my_q, my_d;

    logic        frame_sof;
    logic        overlap;
    logic [12:0] x_hi, y_hi;

    assign frame_sof = (hcount_in == 12'd0) && (vcount_in == 12'd0);

    // Box edges are widened to 13 bits so a pointer parked near 4095 does not
    // wrap its right/bottom edge back to a small value.
    assign x_hi = {1'b0, mx_q} + W_SPAN;
    assign y_hi = {1'b0, my_q} + H_SPAN;

    // Overlap always uses the latched pointer, i.e. the value in force before
    // any update happening on this same frame_sof cycle.
    assign overlap = ((obstacle_x != 12'd0) || (obstacle_y != 12'd0))
                   && (obstacle_x >= mx_q) && ({1'b0, obstacle_x} <= x_hi)
                   && (obstacle_y >= my_q) && ({1'b0, obstacle_y} <= y_hi);

    // NOTE: every variable gets its default at the top of this block so no
    // path through the case leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        hit_d   = 1'b0;
        inv_d   = inv_q;
        go_d    = go_q;
        cnt_d   = cnt_q;
        mx_d    = frame_sof ? mouse_xpos : mx_q;
        my_d    = frame_sof ? mouse_ypos : my_q;

        unique case (state_q)
            IDLE: begin
                // Overlap is ignored while not playing.
                if (game_start) begin
                    state_d = PLAY;
                    hp_d    = HP_LOAD;
                    go_d    = 1'b0;
                    inv_d   = 1'b0;
                end
            end

            PLAY: begin
                if (menu_on) begin
                    state_d = IDLE;
                end else if (overlap) begin
                    hit_d = 1'b1;
                    if (hp_q <= 4'd1) begin
                        // Last life (the <= also keeps hp from wrapping).
                        state_d = DEAD;
                        hp_d    = 4'd0;
                        go_d    = 1'b1;
                    end else begin
                        state_d = INVULN;
                        hp_d    = hp_q - 4'd1;
                        inv_d   = 1'b1;
                        cnt_d   = INV_LOAD;
                    end
                end
            end

            INVULN: begin
                if (menu_on) begin
                    state_d = IDLE;
                    inv_d   = 1'b0;
                    cnt_d   = 8'd0;
                end else if (frame_sof) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = PLAY;
                        inv_d   = 1'b0;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            DEAD: begin
                // menu_on has no effect here; only a new game leaves DEAD.
                if (game_start) begin
                    state_d = PLAY;
                    hp_d    = HP_LOAD;
                    go_d    = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            hp_q    <= 4'd0;
            hit_q   <= 1'b0;
            inv_q   <= 1'b0;
            go_q    <= 1'b0;
            cnt_q   <= 8'd0;
            mx_q    <= 12'd0;
            my_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            hit_q   <= hit_d;
            inv_q   <= inv_d;
            go_q    <= go_d;
            cnt_q   <= cnt_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
        end
    end

    assign hp           = hp_q;
    assign hit          = hit_q;
    assign invulnerable = inv_q;
    assign game_over    = go_q;

endmodule

// File: tb/tb_obstacle_collision_detector.sv
// -----------------------------------------------------------------------------
// tb_obstacle_collision_detector
//
// Stimulus issues one input vector per clock and advances a game-level model
// (lives, frames of invulnerability left, dead/alive) to produce the expected
// registered outputs. The expectation is queued tagged with the cycle in which
// it must be visible; a separate monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_obstacle_collision_detector;

    localparam int PW = 16;
    localparam int PH = 16;
    localparam int MHP = 3;
    localparam int IFR = 60;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [11:0] hcount_in = 12'd1, vcount_in = 12'd0;
    logic [11:0] obstacle_x = '0, obstacle_y = '0;
    logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
    logic        game_start = 1'b0, menu_on = 1'b0;
    logic [3:0]  hp;
    logic        hit, invulnerable, game_over;

    obstacle_collision_detector #(
        .POINTER_W(PW), .POINTER_H(PH), .MAX_HP(MHP), .INVULN_FRAMES(IFR)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .game_start(game_start), .menu_on(menu_on),
        .hp(hp), .hit(hit), .invulnerable(invulnerable), .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int       cyc;
        logic [3:0] hp;
        logic     hit;
        logic     inv;
        logic     go;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- game-level reference model ----------------
    typedef enum {G_MENU, G_ALIVE, G_DEAD} game_e;
    game_e g_mode = G_MENU;
    int    lives = 0;
    int    shield_frames = 0;   // frames of protection left; >0 means invulnerable
    bit    took_hit = 0;
    bit    over = 0;
    int    ptr_x = 0, ptr_y = 0; // pointer as seen at the last frame start
    int    mouse_x_t = 0, mouse_y_t = 0;

    task automatic step(input bit r, input bit sof, input bit gs, input bit mn,
                        input int ox, input int oy);
        bit touch;
        @(posedge pclk);
        #1;
        rst        = r;
        game_start = gs;
        menu_on    = mn;
        obstacle_x = 12'(ox);
        obstacle_y = 12'(oy);
        mouse_xpos = 12'(mouse_x_t);
        mouse_ypos = 12'(mouse_y_t);
        if (sof) begin
            hcount_in = 12'd0;
            vcount_in = 12'd0;
        end else begin
            hcount_in = 12'($urandom_range(1, 1279));
            vcount_in = 12'($urandom_range(0, 1023));
        end

        took_hit = 0;
        if (r) begin
            g_mode = G_MENU; lives = 0; shield_frames = 0; over = 0;
            ptr_x = 0; ptr_y = 0;
        end else begin
            touch = ((ox != 0) || (oy != 0))
                  && ox >= ptr_x && ox < ptr_x + PW
                  && oy >= ptr_y && oy < ptr_y + PH;
            case (g_mode)
                G_MENU, G_DEAD: begin
                    if (gs) begin
                        g_mode = G_ALIVE; lives = MHP; over = 0; shield_frames = 0;
                    end
                end
                G_ALIVE: begin
                    if (mn) begin
                        g_mode = G_MENU; shield_frames = 0;
                    end else if (shield_frames > 0) begin
                        if (sof) shield_frames--;
                    end else if (touch) begin
                        took_hit = 1;
                        lives--;
                        if (lives == 0) begin
                            g_mode = G_DEAD; over = 1;
                        end else begin
                            shield_frames = IFR;
                        end
                    end
                end
            endcase
            if (sof) begin
                ptr_x = mouse_x_t; ptr_y = mouse_y_t;
            end
        end
        exp_q.push_back('{cyc: cyc + 1, hp: 4'(lives), hit: took_hit,
                          inv: (shield_frames > 0), go: over});
    endtask

    // Idle cycles with no obstacle, a frame start every other cycle.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge pclk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (e.cyc != cyc || hp !== e.hp || hit !== e.hit ||
                invulnerable !== e.inv || game_over !== e.go) begin
                n_bad++;
                $display("FAIL out@cyc%0d: got hp=%0d hit=%b inv=%b go=%b, want hp=%0d hit=%b inv=%b go=%b",
                         e.cyc, hp, hit, invulnerable, game_over, e.hp, e.hit, e.inv, e.go);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ox, oy;
        // 1. reset then start
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        mouse_x_t = 500; mouse_y_t = 450;
        step(0, 1, 0, 0, 0, 0);            // latch pointer (500,450)
        step(0, 0, 1, 0, 0, 0);            // game_start -> hp=3
        step(0, 0, 0, 0, 0, 0);
        // 2. hit inside box
        step(0, 0, 0, 0, 507, 460);
        step(0, 0, 0, 0, 0, 0);
        // 3. overlap held for 200 cycles during invulnerability
        for (int i = 0; i < 200; i++) step(0, (i % 50) == 0, 0, 0, 507, 460);
        frames(IFR);
        step(0, 0, 0, 0, 0, 0);
        // 4. edges: (516,450) is just outside, (515,465) is the last inside pixel
        step(0, 0, 0, 0, 516, 450);
        step(0, 0, 0, 0, 500, 466);
        step(0, 0, 0, 0, 499, 455);
        step(0, 0, 0, 0, 515, 465);
        frames(IFR + 1);
        mouse_x_t = 0; mouse_y_t = 0;
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);            // (0,0) = no obstacle
        step(0, 0, 0, 0, 5, 5);            // last life taken
        step(0, 0, 0, 0, 5, 5);            // dead: ignored
        step(0, 0, 0, 1, 5, 5);            // menu_on ignored when dead
        step(0, 0, 1, 0, 5, 5);            // game_start with overlap: load only
        step(0, 0, 0, 0, 0, 0);
        // 5. three separated hits to death, then restart
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 3, 3);
            frames(IFR + 1);
        end
        step(0, 0, 0, 0, 3, 3);
        step(0, 0, 1, 0, 0, 0);
        // sof and overlap together: hit uses old pointer (0,0)
        mouse_x_t = 2000; mouse_y_t = 2000;
        step(0, 1, 0, 0, 8, 8);
        frames(IFR + 1);
        // 6. menu_on with overlap in PLAY
        step(0, 0, 0, 1, 2005, 2005);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 2005, 2005);      // hit -> INVULN
        frames(3);
        step(1, 0, 0, 0, 2005, 2005);      // reset mid-INVULN
        step(0, 0, 0, 0, 0, 0);
        // pointer near the far corner: box must not wrap
        mouse_x_t = 4090; mouse_y_t = 4090;
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 4095, 4095);
        frames(IFR + 1);
        step(0, 0, 0, 0, 5, 5);

        // randomized play
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mouse_x_t = ($urandom_range(0, 7) == 0) ? $urandom_range(4070, 4095)
                                                         : $urandom_range(0, 4095);
                mouse_y_t = ($urandom_range(0, 7) == 0) ? $urandom_range(4070, 4095)
                                                         : $urandom_range(0, 4095);
            end
            ox = ptr_x + $urandom_range(0, 40) - 12;
            oy = ptr_y + $urandom_range(0, 40) - 12;
            if (ox < 0) ox = 0;
            if (ox > 4095) ox = 4095;
            if (oy < 0) oy = 0;
            if (oy > 4095) oy = 4095;
            if ($urandom_range(0, 9) == 0) begin ox = 0; oy = 0; end
            step($urandom_range(0, 799) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 59) == 0,
                 ox, oy);
        end

        // drain with a bounded wait
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
